// File: rtl/adder_pkg.sv
// Shared encodings and helpers for the serial arithmetic blocks.
// Imported by serial_subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = ai - bi - bin.
// Purely combinational; reused every cycle by the serial datapath.
module full_subtractor (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ai ^ bi ^ bin;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles.
// start/busy/done handshake; results held until the next completion.
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int RW    = (WIDTH > 1) ? WIDTH - 1 : 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [RW-1:0]    r_res_sr;
  logic             r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic [RW-1:0]    w_res_shift;

  full_subtractor u_fs (
    .ai   (r_a_sr[0]),
    .bi   (r_b_sr[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // The bit leaving the LSB is never needed, so only WIDTH-1 bits are kept.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res_next  = w_d;
      assign w_res_shift = r_res_sr;
    end else begin : g_wn
      assign w_res_next  = {w_d, r_res_sr};
      assign w_res_shift = w_res_next[WIDTH-1:1];
    end
  endgenerate

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_res_sr <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_shift;
          r_bin    <= w_bout;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff   <= w_res_next;
            r_borrow <= w_bout;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Expected {borrow,diff} comes from plain (WIDTH+1)-bit arithmetic.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;

  int total = 0;
  int bad   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] hold8 = '0;
  logic [1:0] hold1 = '0;
  bit         mon_en = 1'b0;
  int         bcnt8 = 0, bcnt1 = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .busy(busy1), .done(done1),
    .diff(diff1), .borrow(borrow1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] x, y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r += 512;
    return 9'(r);
  endfunction

  function automatic logic [1:0] ref1(input logic [0:0] x, y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r += 4;
    return 2'(r);
  endfunction

  // Monitors: pop on done, check latency via busy count and held outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done8) begin
        chk("w8_busy_len", bcnt8, 8);
        chk("w8_busy_with_done", busy8, 0);
        bcnt8 = 0;
        if (q8.size() == 0) begin
          chk("w8_unexpected_done", 1, 0);
        end else begin
          hold8 = q8.pop_front();
          chk("w8_result", {borrow8, diff8}, hold8);
        end
      end else begin
        chk("w8_hold", {borrow8, diff8}, hold8);
        if (busy8) bcnt8++;
        else bcnt8 = 0;
      end
      if (done1) begin
        chk("w1_busy_len", bcnt1, 1);
        bcnt1 = 0;
        if (q1.size() == 0) begin
          chk("w1_unexpected_done", 1, 0);
        end else begin
          hold1 = q1.pop_front();
          chk("w1_result", {borrow1, diff1}, hold1);
        end
      end else begin
        chk("w1_hold", {borrow1, diff1}, hold1);
        if (busy1) bcnt1++;
        else bcnt1 = 0;
      end
    end
  end

  task automatic op8(input logic [7:0] x, y);
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    q8.push_back(ref8(x, y));
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic wait8;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 20);
    if (!done8) chk("w8_done_timeout", 0, 1);
  endtask

  task automatic op1(input logic [0:0] x, y);
    a1 = x;
    b1 = y;
    start1 = 1'b1;
    q1.push_back(ref1(x, y));
    @(posedge clk);
    #1 start1 = 1'b0;
  endtask

  task automatic wait1;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done1 && n < 6);
    if (!done1) chk("w1_done_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_borrow", borrow8, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    op8(8'h5A, 8'h23); wait8; @(posedge clk); #1;
    op8(8'h10, 8'h20); wait8; @(posedge clk); #1;
    op8(8'h00, 8'h00); wait8; @(posedge clk); #1;
    op8(8'hFF, 8'hFF); wait8; @(posedge clk); #1;

    // start toggled mid-run with junk operands, then back-to-back op
    op8(8'hC3, 8'h41);
    for (int i = 0; i < 3; i++) begin
      start8 = 1'b1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge clk);
      #1 start8 = 1'b0;
    end
    wait8;
    op8(8'h01, 8'h02);
    @(negedge clk);
    chk("b2b_busy", busy8, 1);
    wait8; @(posedge clk); #1;

    // reset at RUN cycle 4 aborts the operation
    op8(8'h80, 8'h01);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hold8 = '0;
    hold1 = '0;
    void'(q8.pop_back());
    @(negedge clk);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_borrow", borrow8, 0);
    repeat (12) @(posedge clk);
    #1;

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      op8(ra, rb);
      wait8;
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      op1(1'(i >> 1), 1'(i));
      wait1;
    end
    op1(1'b1, 1'b0);
    wait1;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("w8_queue_empty", q8.size(), 0);
    chk("w1_queue_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
